axi4_stream_wr_master: RTL

- AXI4 burst write master: drains a 256-bit data stream into DDR through the PL S01 AXI port.
- It is the write-direction counterpart of the PL 256-bit read master. Same ps_clk domain, same AXI4 ID/address/data widths.
- Controlled by start/base/length inputs from the AXI-Lite register block.
- Reports busy, done and error.

---
 rtl/axi4_stream_wr_master.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/axi4_stream_wr_master.sv
// AXI4 INCR burst write master draining a stream to memory, one burst in flight; empty start-to-done is 2 cycles.
// W backpressure passes straight to s_tready; WR_MASTER_BTIMEOUT_EN adds a B-response watchdog.
module axi4_stream_wr_master #(
  parameter int ID_W           = 4,
  parameter int ADDR_W         = 40,
  parameter int DATA_W         = 256,
  parameter int BURST_LEN      = 16,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                ps_clk,
  input  logic                ps_rstb,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    num_bursts,
  output logic                busy,
  output logic                done,
  output logic                error,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic [DATA_W-1:0]   s_tdata,
  output logic [ID_W-1:0]     m_awid,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_awlock,
  output logic [3:0]          m_awcache,
  output logic [2:0]          m_awprot,
  output logic [3:0]          m_awqos,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [ID_W-1:0]     m_bid,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);

  localparam int BYTES       = DATA_W / 8;
  localparam int BURST_BYTES = BYTES * BURST_LEN;
  localparam int ALIGN_W     = $clog2(BURST_BYTES);
  localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                w_fire;
  logic                unused_ok;

`ifdef WR_MASTER_BTIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0]     wd_q, wd_d;
  assign unused_ok = ^m_bid;
`else
  assign unused_ok = ^{m_bid, (TIMEOUT_CYCLES != 0)};
`endif

  assign w_fire = (state_q == S_W) && s_tvalid && m_wready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    beat_d      = beat_q;
    error_d     = error_q;
`ifdef WR_MASTER_BTIMEOUT_EN
    wd_d        = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          if (num_bursts == '0) begin
            state_d = S_DONE;
          end else if (base_addr[ALIGN_W-1:0] != '0) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else begin
            addr_d      = base_addr;
            remaining_d = num_bursts;
            state_d     = S_AW;
          end
        end
      end
      S_AW: begin
        if (m_awready) begin
          beat_d  = '0;
          state_d = S_W;
        end
      end
      S_W: begin
        if (w_fire) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) state_d = S_B;
        end
      end
      S_B: begin
        if (m_bvalid) begin
          if (m_bresp != 2'b00) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else begin
            // address wraps silently at 2^ADDR_W
            remaining_d = remaining_q - CNT_W'(1);
            addr_d      = addr_q + ADDR_W'(BURST_BYTES);
            state_d     = (remaining_q == CNT_W'(1)) ? S_DONE : S_AW;
          end
        end
`ifdef WR_MASTER_BTIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end
        wd_d = wd_q + WD_W'(1);
`endif
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_AW) || (state_d == S_W) || (state_d == S_B);
    done_d = (state_q == S_DONE);
  end

  always_ff @(posedge ps_clk or negedge ps_rstb) begin
    if (!ps_rstb) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      beat_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef WR_MASTER_BTIMEOUT_EN
      wd_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      beat_q      <= beat_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef WR_MASTER_BTIMEOUT_EN
      wd_q        <= wd_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

  assign m_awid    = '0;
  assign m_awaddr  = addr_q;
  assign m_awlen   = 8'(BURST_LEN - 1);
  assign m_awsize  = 3'($clog2(BYTES));
  assign m_awburst = 2'b01;
  assign m_awlock  = 1'b0;
  assign m_awcache = 4'b0011;
  assign m_awprot  = '0;
  assign m_awqos   = '0;
  assign m_awvalid = (state_q == S_AW);

  assign m_wdata   = s_tdata;
  assign m_wstrb   = '1;
  assign m_wvalid  = (state_q == S_W) && s_tvalid;
  assign s_tready  = (state_q == S_W) && m_wready;
  assign m_wlast   = (state_q == S_W) && (beat_q == LAST_BEAT);
  assign m_bready  = (state_q == S_B);

endmodule
